// File: rtl/l2_cache_miss_scheduler.sv
// L2 miss scheduler: queues classified misses in order, reads memory once per
// original (non-duplicate) miss and replays every entry into the L2 pipeline.
package l2_cache_miss_scheduler_pkg;
  typedef logic [15:0] cache_line_index_t;
  typedef logic [31:0] cache_line_data_t;
  typedef enum logic {RETIRE_IDLE = 1'b0, RETIRE_REPLAY = 1'b1} retire_state_t;
endpackage

module l2_cache_miss_scheduler
  import l2_cache_miss_scheduler_pkg::*;
#(
  parameter int QUEUE_SIZE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss_valid,
  input  cache_line_index_t miss_adr,
  input  logic              miss_duplicate,
  output logic              miss_ready,
  output logic              mem_rd_valid,
  output cache_line_index_t mem_rd_adr,
  input  logic              mem_rd_ready,
  input  logic              mem_resp_valid,
  input  cache_line_data_t  mem_resp_data,
  output logic              mem_resp_ready,
  output logic              fill_valid,
  output cache_line_index_t fill_adr,
  output cache_line_data_t  fill_data,
  output logic              fill_duplicate,
  input  logic              fill_ready,
  output logic [$clog2(QUEUE_SIZE):0] occupancy,
  output retire_state_t     debug_retire_state
);
  localparam int PTR_W = $clog2(QUEUE_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_SIZE);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // a valid source holds its payload stable until that edge.

  cache_line_index_t adr_q [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0] dup_q;
  logic [PTR_W-1:0] head, issue, tail;
  logic [CNT_W-1:0] issued_cnt;   // entries between head and issue
  logic [CNT_W-1:0] outstanding;  // reads accepted by memory, not yet answered
  logic buf_full;
  cache_line_data_t buf_data;
  retire_state_t state, state_next;

  logic enq_fire, unexamined, issue_adv, rd_fire, resp_fire, retire_fire, head_dup;

  assign miss_ready     = (occupancy != FULL_CNT);
  assign enq_fire       = miss_valid && miss_ready;
  // Pointer equality is ambiguous when full, so examine-pending uses counts.
  assign unexamined     = (occupancy != issued_cnt);
  assign mem_rd_valid   = unexamined && !dup_q[issue];
  assign mem_rd_adr     = adr_q[issue];
  assign issue_adv      = unexamined && (dup_q[issue] || mem_rd_ready);
  assign rd_fire        = mem_rd_valid && mem_rd_ready;
  assign mem_resp_ready = !buf_full;
  // A response with nothing outstanding is dropped rather than captured.
  assign resp_fire      = mem_resp_valid && mem_resp_ready && (outstanding != '0);
  assign head_dup       = dup_q[head];
  assign retire_fire    = (state == RETIRE_REPLAY) && fill_ready;
  assign debug_retire_state = state;

  always_comb begin
    state_next     = state;
    fill_valid     = 1'b0;
    fill_duplicate = 1'b0;
    fill_adr       = adr_q[head];
    fill_data      = buf_data;
    case (state)
      RETIRE_IDLE: begin
        if ((issued_cnt != '0) && (head_dup || buf_full)) state_next = RETIRE_REPLAY;
      end
      RETIRE_REPLAY: begin
        fill_valid     = 1'b1;
        fill_duplicate = head_dup;
        if (fill_ready) state_next = RETIRE_IDLE;
      end
      default: state_next = RETIRE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RETIRE_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (enq_fire) adr_q[tail] <= miss_adr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dup_q       <= '0;
      head        <= '0;
      issue       <= '0;
      tail        <= '0;
      occupancy   <= '0;
      issued_cnt  <= '0;
      outstanding <= '0;
      buf_full    <= 1'b0;
      buf_data    <= '0;
    end else begin
      if (enq_fire) begin
        dup_q[tail] <= miss_duplicate;
        tail        <= tail + PTR_W'(1);
      end
      if (issue_adv)   issue <= issue + PTR_W'(1);
      if (retire_fire) head  <= head + PTR_W'(1);
      occupancy   <= occupancy + CNT_W'(enq_fire) - CNT_W'(retire_fire);
      issued_cnt  <= issued_cnt + CNT_W'(issue_adv) - CNT_W'(retire_fire);
      outstanding <= outstanding + CNT_W'(rd_fire) - CNT_W'(resp_fire);
      // Capture and release are exclusive: capture needs the buffer empty.
      if (resp_fire) begin
        buf_full <= 1'b1;
        buf_data <= mem_resp_data;
      end else if (retire_fire && !head_dup) begin
        buf_full <= 1'b0;
      end
    end
  end

  no_orphan_response: assert property (@(posedge clk) disable iff (reset)
    mem_resp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_l2_cache_miss_scheduler.sv
// Directed bench for l2_cache_miss_scheduler: one task per scenario, a cycle
// task that drives inputs at negedge and logs handshakes 1ns later.
module tb_l2_cache_miss_scheduler;
  import l2_cache_miss_scheduler_pkg::*;
  localparam int QUEUE_SIZE = 8;

  logic clk = 1'b0;
  logic reset;
  logic miss_valid, miss_duplicate, miss_ready;
  cache_line_index_t miss_adr, mem_rd_adr, fill_adr;
  logic mem_rd_valid, mem_rd_ready, mem_resp_valid, mem_resp_ready;
  cache_line_data_t mem_resp_data, fill_data;
  logic fill_valid, fill_duplicate, fill_ready;
  logic [3:0] occupancy;
  retire_state_t debug_retire_state;

  always #5 clk = ~clk;

  l2_cache_miss_scheduler #(.QUEUE_SIZE(QUEUE_SIZE)) dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_adr(miss_adr), .miss_duplicate(miss_duplicate),
    .miss_ready(miss_ready),
    .mem_rd_valid(mem_rd_valid), .mem_rd_adr(mem_rd_adr), .mem_rd_ready(mem_rd_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_ready(mem_resp_ready),
    .fill_valid(fill_valid), .fill_adr(fill_adr), .fill_data(fill_data),
    .fill_duplicate(fill_duplicate), .fill_ready(fill_ready),
    .occupancy(occupancy), .debug_retire_state(debug_retire_state)
  );

  typedef struct packed {logic [15:0] adr; logic dup;} miss_t;
  miss_t       miss_q[$];
  logic [15:0] rd_log[$];
  logic [15:0] rd_pend[$];
  logic [15:0] fill_adr_log[$];
  logic [31:0] fill_data_log[$];
  logic        fill_dup_log[$];
  bit   rd_rand, fill_rand, resp_en;
  logic rd_ready_lvl, fill_ready_lvl;
  int   checks = 0;
  int   fails = 0;

  function automatic logic [31:0] data_of(input logic [15:0] a);
    return {~a, a};
  endfunction

  task automatic cycle();
    @(negedge clk);
    mem_rd_ready = rd_rand ? 1'($urandom_range(0, 1)) : rd_ready_lvl;
    fill_ready   = fill_rand ? 1'($urandom_range(0, 1)) : fill_ready_lvl;
    if (miss_q.size() != 0) begin
      miss_valid = 1'b1; miss_adr = miss_q[0].adr; miss_duplicate = miss_q[0].dup;
    end else begin
      miss_valid = 1'b0;
    end
    if (resp_en && rd_pend.size() != 0) begin
      mem_resp_valid = 1'b1; mem_resp_data = data_of(rd_pend[0]);
    end else begin
      mem_resp_valid = 1'b0;
    end
    #1;
    if (!reset) begin
      if (miss_valid && miss_ready) void'(miss_q.pop_front());
      if (mem_rd_valid && mem_rd_ready) begin
        rd_log.push_back(mem_rd_adr); rd_pend.push_back(mem_rd_adr);
      end
      if (mem_resp_valid && mem_resp_ready) void'(rd_pend.pop_front());
      if (fill_valid && fill_ready) begin
        fill_adr_log.push_back(fill_adr);
        fill_data_log.push_back(fill_data);
        fill_dup_log.push_back(fill_duplicate);
      end
    end
  endtask

  task automatic clear_logs();
    rd_log.delete(); fill_adr_log.delete(); fill_data_log.delete(); fill_dup_log.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (occupancy !== 4'd0) begin fails++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    checks++; if (miss_ready !== 1'b1) begin fails++; $display("FAIL reset_miss_ready: got %b expected 1", miss_ready); end
    checks++; if (mem_rd_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_rd_valid: got %b expected 0", mem_rd_valid); end
    checks++; if (mem_resp_ready !== 1'b1) begin fails++; $display("FAIL reset_mem_resp_ready: got %b expected 1", mem_resp_ready); end
    checks++; if (fill_valid !== 1'b0) begin fails++; $display("FAIL reset_fill_valid: got %b expected 0", fill_valid); end
    checks++; if (fill_duplicate !== 1'b0) begin fails++; $display("FAIL reset_fill_duplicate: got %b expected 0", fill_duplicate); end
    checks++; if (debug_retire_state !== RETIRE_IDLE) begin fails++; $display("FAIL reset_state: got %0d expected IDLE", debug_retire_state); end
    reset = 1'b0;
    cycle();
    checks++; if (mem_rd_valid !== 1'b0 || fill_valid !== 1'b0) begin fails++; $display("FAIL idle_after_reset: rd_valid %b fill_valid %b expected 0 0", mem_rd_valid, fill_valid); end
  endtask

  task automatic test_single_miss();
    bit done;
    clear_logs();
    rd_ready_lvl = 1'b1; fill_ready_lvl = 1'b1; resp_en = 1'b0;
    miss_q.push_back('{16'h0010, 1'b0});
    cycle(); cycle();
    checks++; if (rd_log.size() != 1) begin fails++; $display("FAIL single_rd_latency: got %0d reads expected 1 after 2 cycles", rd_log.size()); end
    checks++; if (rd_log[0] !== 16'h0010) begin fails++; $display("FAIL single_rd_adr: got %h expected 0010", rd_log[0]); end
    repeat (3) cycle();
    resp_en = 1'b1;
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin cycle(); done = (fill_adr_log.size() == 1); end
    checks++; if (!done) begin fails++; $display("FAIL single_fill_timeout: got %0d fills expected 1", fill_adr_log.size()); end
    repeat (2) cycle();
    checks++; if (fill_adr_log[0] !== 16'h0010) begin fails++; $display("FAIL single_fill_adr: got %h expected 0010", fill_adr_log[0]); end
    checks++; if (fill_data_log[0] !== data_of(16'h0010)) begin fails++; $display("FAIL single_fill_data: got %h expected %h", fill_data_log[0], data_of(16'h0010)); end
    checks++; if (fill_dup_log[0] !== 1'b0) begin fails++; $display("FAIL single_fill_dup: got %b expected 0", fill_dup_log[0]); end
    checks++; if (rd_log.size() != 1) begin fails++; $display("FAIL single_rd_count: got %0d expected 1", rd_log.size()); end
    checks++; if (occupancy !== 4'd0) begin fails++; $display("FAIL single_occupancy: got %0d expected 0", occupancy); end
  endtask

  task automatic test_dup_order();
    bit done;
    logic [15:0] exp_adr [3];
    logic        exp_dup [3];
    exp_adr = '{16'h0010, 16'h0020, 16'h0010};
    exp_dup = '{1'b0, 1'b0, 1'b1};
    clear_logs();
    rd_ready_lvl = 1'b1; fill_ready_lvl = 1'b1; resp_en = 1'b1;
    for (int i = 0; i < 3; i++) miss_q.push_back('{exp_adr[i], exp_dup[i]});
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin cycle(); done = (fill_adr_log.size() == 3); end
    checks++; if (!done) begin fails++; $display("FAIL dup_timeout: got %0d fills expected 3", fill_adr_log.size()); end
    repeat (3) cycle();
    checks++; if (rd_log.size() != 2) begin fails++; $display("FAIL dup_rd_count: got %0d expected 2", rd_log.size()); end
    checks++; if (rd_log[0] !== 16'h0010 || rd_log[1] !== 16'h0020) begin fails++; $display("FAIL dup_rd_order: got %h %h expected 0010 0020", rd_log[0], rd_log[1]); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (fill_adr_log[i] !== exp_adr[i]) begin fails++; $display("FAIL dup_fill_adr[%0d]: got %h expected %h", i, fill_adr_log[i], exp_adr[i]); end
      checks++; if (fill_dup_log[i] !== exp_dup[i]) begin fails++; $display("FAIL dup_fill_dup[%0d]: got %b expected %b", i, fill_dup_log[i], exp_dup[i]); end
    end
    checks++; if (fill_data_log[1] !== data_of(16'h0020)) begin fails++; $display("FAIL dup_fill_data: got %h expected %h", fill_data_log[1], data_of(16'h0020)); end
  endtask

  task automatic test_full_queue();
    bit done;
    clear_logs();
    rd_ready_lvl = 1'b0; fill_ready_lvl = 1'b1; resp_en = 1'b0;
    for (int i = 0; i < 9; i++) miss_q.push_back('{16'h0040 + 16'(i), 1'b0});
    repeat (12) cycle();
    checks++; if (occupancy !== 4'd8) begin fails++; $display("FAIL full_occupancy: got %0d expected 8", occupancy); end
    checks++; if (miss_ready !== 1'b0) begin fails++; $display("FAIL full_miss_ready: got %b expected 0", miss_ready); end
    checks++; if (miss_q.size() != 1) begin fails++; $display("FAIL full_ninth_rejected: got %0d pending expected 1", miss_q.size()); end
    rd_ready_lvl = 1'b1; resp_en = 1'b1;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin cycle(); done = (fill_adr_log.size() == 1); end
    checks++; if (!done) begin fails++; $display("FAIL full_first_fill_timeout: got %0d fills expected 1", fill_adr_log.size()); end
    checks++; if (miss_ready !== 1'b0) begin fails++; $display("FAIL full_ready_during_retire: got %b expected 0", miss_ready); end
    cycle();
    checks++; if (miss_ready !== 1'b1) begin fails++; $display("FAIL full_ready_after_retire: got %b expected 1", miss_ready); end
    checks++; if (miss_q.size() != 0) begin fails++; $display("FAIL full_ninth_accepted: got %0d pending expected 0", miss_q.size()); end
    cycle();
    checks++; if (occupancy !== 4'd8) begin fails++; $display("FAIL full_refill_occupancy: got %0d expected 8", occupancy); end
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin cycle(); done = (fill_adr_log.size() == 9); end
    checks++; if (!done) begin fails++; $display("FAIL full_drain_timeout: got %0d fills expected 9", fill_adr_log.size()); end
    for (int i = 0; i < 9; i++) begin
      checks++; if (fill_adr_log[i] !== 16'h0040 + 16'(i)) begin fails++; $display("FAIL full_fill_adr[%0d]: got %h expected %h", i, fill_adr_log[i], 16'h0040 + 16'(i)); end
    end
    repeat (2) cycle();
  endtask

  task automatic test_backpressure();
    bit done;
    clear_logs();
    rd_ready_lvl = 1'b1; fill_ready_lvl = 1'b0; resp_en = 1'b1;
    miss_q.push_back('{16'h0050, 1'b0});
    miss_q.push_back('{16'h0060, 1'b0});
    repeat (6) cycle();
    checks++; if (rd_pend.size() != 1) begin fails++; $display("FAIL bp_second_resp_pending: got %0d expected 1", rd_pend.size()); end
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (mem_resp_ready !== 1'b0) begin fails++; $display("FAIL bp_resp_ready[%0d]: got %b expected 0", i, mem_resp_ready); end
      checks++; if (fill_valid !== 1'b1) begin fails++; $display("FAIL bp_fill_valid[%0d]: got %b expected 1", i, fill_valid); end
      checks++; if (fill_adr !== 16'h0050) begin fails++; $display("FAIL bp_fill_adr[%0d]: got %h expected 0050", i, fill_adr); end
      checks++; if (fill_data !== data_of(16'h0050)) begin fails++; $display("FAIL bp_fill_data[%0d]: got %h expected %h", i, fill_data, data_of(16'h0050)); end
    end
    fill_ready_lvl = 1'b1;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin cycle(); done = (fill_adr_log.size() == 2); end
    checks++; if (!done) begin fails++; $display("FAIL bp_timeout: got %0d fills expected 2", fill_adr_log.size()); end
    checks++; if (fill_adr_log[0] !== 16'h0050 || fill_adr_log[1] !== 16'h0060) begin fails++; $display("FAIL bp_fill_order: got %h %h expected 0050 0060", fill_adr_log[0], fill_adr_log[1]); end
    checks++; if (fill_data_log[1] !== data_of(16'h0060)) begin fails++; $display("FAIL bp_second_data: got %h expected %h", fill_data_log[1], data_of(16'h0060)); end
    repeat (2) cycle();
  endtask

  task automatic test_wrap_around();
    bit done;
    clear_logs();
    rd_rand = 1; fill_rand = 1; resp_en = 1'b1;
    for (int i = 0; i < 20; i++) miss_q.push_back('{16'h0100 + 16'(i), 1'b0});
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin cycle(); done = (fill_adr_log.size() == 20); end
    checks++; if (!done) begin fails++; $display("FAIL wrap_timeout: got %0d fills expected 20", fill_adr_log.size()); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (fill_adr_log[i] !== 16'h0100 + 16'(i)) begin fails++; $display("FAIL wrap_fill_adr[%0d]: got %h expected %h", i, fill_adr_log[i], 16'h0100 + 16'(i)); end
      checks++; if (fill_data_log[i] !== data_of(16'h0100 + 16'(i))) begin fails++; $display("FAIL wrap_fill_data[%0d]: got %h expected %h", i, fill_data_log[i], data_of(16'h0100 + 16'(i))); end
    end
    rd_rand = 0; fill_rand = 0;
    repeat (3) cycle();
    checks++; if (occupancy !== 4'd0) begin fails++; $display("FAIL wrap_occupancy: got %0d expected 0", occupancy); end
  endtask

  task automatic test_reset_mid();
    bit done;
    clear_logs();
    rd_ready_lvl = 1'b1; fill_ready_lvl = 1'b0; resp_en = 1'b0;
    for (int i = 0; i < 3; i++) miss_q.push_back('{16'h0070 + 16'(i), 1'b0});
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin cycle(); done = (rd_log.size() == 1); end
    rd_ready_lvl = 1'b0;
    repeat (4) cycle();
    checks++; if (occupancy !== 4'd3 || rd_pend.size() != 1) begin fails++; $display("FAIL mid_setup: got occupancy %0d outstanding %0d expected 3 1", occupancy, rd_pend.size()); end
    reset = 1'b1;
    #1;
    checks++; if (occupancy !== 4'd0) begin fails++; $display("FAIL mid_reset_occupancy: got %0d expected 0", occupancy); end
    checks++; if (mem_rd_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_rd_valid: got %b expected 0", mem_rd_valid); end
    checks++; if (fill_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_fill_valid: got %b expected 0", fill_valid); end
    checks++; if (miss_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_miss_ready: got %b expected 1", miss_ready); end
    checks++; if (mem_resp_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_resp_ready: got %b expected 1", mem_resp_ready); end
    rd_pend.delete(); miss_q.delete();
    #2 reset = 1'b0;
    clear_logs();
    rd_ready_lvl = 1'b1; fill_ready_lvl = 1'b1; resp_en = 1'b1;
    miss_q.push_back('{16'h0080, 1'b0});
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin cycle(); done = (fill_adr_log.size() == 1); end
    checks++; if (!done) begin fails++; $display("FAIL mid_post_reset_timeout: got %0d fills expected 1", fill_adr_log.size()); end
    checks++; if (rd_log.size() != 1 || rd_log[0] !== 16'h0080) begin fails++; $display("FAIL mid_post_reset_rd: got %0d reads first %h expected 1 0080", rd_log.size(), rd_log[0]); end
    checks++; if (fill_adr_log[0] !== 16'h0080 || fill_data_log[0] !== data_of(16'h0080)) begin fails++; $display("FAIL mid_post_reset_fill: got %h %h expected 0080 %h", fill_adr_log[0], fill_data_log[0], data_of(16'h0080)); end
  endtask

  initial begin
    reset = 1'b1;
    miss_valid = 1'b0; miss_adr = '0; miss_duplicate = 1'b0;
    mem_rd_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; fill_ready = 1'b0;
    rd_rand = 0; fill_rand = 0; resp_en = 0; rd_ready_lvl = 1'b0; fill_ready_lvl = 1'b0;
    test_reset();
    test_single_miss();
    test_dup_order();
    test_full_queue();
    test_backpressure();
    test_wrap_around();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
